// File: rtl/path_segment_sequencer.sv
// Command sequencer for the two-operand add/multiply path segment: register file,
// operand drive, result capture/writeback and a self-check against an expected value.
module path_segment_sequencer #(
  parameter int NREG = 4,
  parameter int DW   = 16,
  parameter int MW   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(NREG)-1:0] wr_addr,
  input  logic [DW-1:0]           wr_data,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_op,
  input  logic [$clog2(NREG)-1:0] cmd_src_a,
  input  logic [$clog2(NREG)-1:0] cmd_src_b,
  input  logic [$clog2(NREG)-1:0] cmd_dst,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DW-1:0]           rsp_data,
  output logic                    rsp_err,
  output logic [DW-1:0]           seg_r1,
  output logic [DW-1:0]           seg_r2,
  output logic [DW-1:0]           seg_r3,
  output logic [DW-1:0]           seg_r4,
  output logic                    seg_s1,
  output logic                    seg_s2,
  output logic                    seg_op,
  input  logic [DW-1:0]           seg_regout
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EXEC = 3'd2,
    CAPT = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   rf [NREG];
  logic [DW-1:0]   expected;
  logic [AW-1:0]   dst;
  logic            accept;

  // Reference result; multiply is an unsigned product of the low MW bits.
  function automatic logic [DW-1:0] expect_result(input logic op,
                                                  input logic [DW-1:0] a,
                                                  input logic [DW-1:0] b);
    logic [DW-1:0] a_ext;
    logic [DW-1:0] b_ext;
    a_ext = {{(DW-MW){1'b0}}, a[MW-1:0]};
    b_ext = {{(DW-MW){1'b0}}, b[MW-1:0]};
    if (op) begin
      expect_result = a_ext * b_ext;
    end else begin
      expect_result = a + b;
    end
  endfunction

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && (state == IDLE);
  assign seg_r2    = {DW{1'b0}};
  assign seg_r3    = {DW{1'b0}};
  assign seg_s1    = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: state_nxt = EXEC;
      EXEC: state_nxt = CAPT;
      CAPT: state_nxt = RESP;
      RESP: begin
        // The first RESP cycle only raises rsp_valid; rsp_ready counts once it is up.
        if (rsp_valid && rsp_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= {DW{1'b0}};
      end
      seg_r1    <= {DW{1'b0}};
      seg_r4    <= {DW{1'b0}};
      seg_s2    <= 1'b0;
      seg_op    <= 1'b0;
      expected  <= {DW{1'b0}};
      dst       <= {AW{1'b0}};
      rsp_valid <= 1'b0;
      rsp_data  <= {DW{1'b0}};
      rsp_err   <= 1'b0;
    end else begin
      if (wr_en) begin
        rf[wr_addr] <= wr_data;
      end
      // Writeback is the later assignment, so it beats a same-cycle host write.
      if (state == CAPT) begin
        rf[dst] <= seg_regout;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            seg_r1   <= rf[cmd_src_a];
            seg_r4   <= rf[cmd_src_b];
            seg_s2   <= 1'b1;
            seg_op   <= cmd_op;
            dst      <= cmd_dst;
            expected <= expect_result(cmd_op, rf[cmd_src_a], rf[cmd_src_b]);
          end
        end
        CAPT: begin
          rsp_data <= seg_regout;
          rsp_err  <= (seg_regout != expected);
          seg_r1   <= {DW{1'b0}};
          seg_r4   <= {DW{1'b0}};
          seg_s2   <= 1'b0;
          seg_op   <= 1'b0;
        end
        RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_segment_sequencer.sv
// Scoreboard bench for path_segment_sequencer with a behavioural model of the
// 2-clock add/multiply segment and an injectable result offset.
module tb_path_segment_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [15:0] wr_data = 16'd0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [1:0]  cmd_src_a = 2'd0;
  logic [1:0]  cmd_src_b = 2'd0;
  logic [1:0]  cmd_dst = 2'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] seg_r1, seg_r2, seg_r3, seg_r4;
  logic        seg_s1, seg_s2, seg_op;
  logic [15:0] seg_regout;

  logic [15:0] adata = 16'd0;
  logic [15:0] bdata = 16'd0;
  logic [15:0] regout = 16'd0;
  logic [15:0] delta = 16'd0;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int acc_edge = -100;
  logic [16:0] exp_q [$];

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [15:0] prev_data = 16'd0;
  logic        prev_err = 1'b0;

  path_segment_sequencer dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .seg_r1(seg_r1), .seg_r2(seg_r2), .seg_r3(seg_r3), .seg_r4(seg_r4),
    .seg_s1(seg_s1), .seg_s2(seg_s2), .seg_op(seg_op), .seg_regout(seg_regout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Segment model: operand registers reload every clock, result registered one clock later.
  always @(posedge clk) begin
    adata  <= seg_s1 ? seg_r2 : seg_r1;
    bdata  <= seg_s2 ? seg_r4 : seg_r3;
    regout <= seg_op ? ({8'h00, adata[7:0]} * {8'h00, bdata[7:0]}) : (adata + bdata);
  end
  assign seg_regout = regout + delta;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: latency, hold stability under backpressure, and scoreboard pops.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst) begin
      if (cmd_valid && cmd_ready) acc_edge = cyc + 1;
      if (rsp_valid && !prev_valid) begin
        vectors++;
        if (cyc != acc_edge + 4) begin
          errors++;
          $display("FAIL latency: rsp_valid at edge %0d, expected edge %0d", cyc, acc_edge + 4);
        end
      end
      if (rsp_valid && prev_valid && !prev_ready) begin
        vectors++;
        if (rsp_data !== prev_data || rsp_err !== prev_err) begin
          errors++;
          $display("FAIL hold_stable: got %h/%b, expected %h/%b", rsp_data, rsp_err, prev_data, prev_err);
        end
      end
      if (rsp_valid && rsp_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got %h with no response expected", rsp_data);
        end else begin
          e = exp_q.pop_front();
          if (rsp_data !== e[15:0] || rsp_err !== e[16]) begin
            errors++;
            $display("FAIL rsp: got data %h err %b, expected data %h err %b", rsp_data, rsp_err, e[15:0], e[16]);
          end
        end
      end
    end
    prev_valid = rsp_valid;
    prev_ready = rsp_ready;
    prev_data  = rsp_data;
    prev_err   = rsp_err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Offers one command for a single accepting clock; returns just after the accept edge.
  task automatic issue(input logic op, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
                       input logic [15:0] ed, input logic ee, input bit push);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      vectors++;
      errors++;
      $display("FAIL issue_timeout: cmd_ready %b, expected 1", cmd_ready);
    end
    cmd_op = op; cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_valid = 1'b1;
    if (push) exp_q.push_back({ee, ed});
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses pending, expected 0", exp_q.size());
    end
    tick();
  endtask

  initial begin
    #3;
    check("reset_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    check("reset_seg_r1", seg_r1, 16'd0);
    check("reset_seg_ctl", {13'd0, seg_s2, seg_op, rsp_err}, 16'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("cmd_ready_after_reset", {15'd0, cmd_ready}, 16'd1);

    issue(1'b0, 2'd0, 2'd1, 2'd0, 16'h0000, 1'b0, 1'b1);
    drain();
    issue(1'b1, 2'd2, 2'd3, 2'd2, 16'h0000, 1'b0, 1'b1);
    drain();

    // Add with wrap, then read the destination back through r3 (still 0).
    preload(2'd0, 16'hFFF0);
    preload(2'd1, 16'h0020);
    issue(1'b0, 2'd0, 2'd1, 2'd2, 16'h0010, 1'b0, 1'b1);
    drain();
    issue(1'b0, 2'd2, 2'd3, 2'd3, 16'h0010, 1'b0, 1'b1);
    drain();

    preload(2'd0, 16'h12FF);
    preload(2'd1, 16'h3402);
    issue(1'b1, 2'd0, 2'd1, 2'd0, 16'h01FE, 1'b0, 1'b1);
    drain();

    // Backpressure: r2 = 0x0010, so 2+2 gives 0x0020.
    rsp_ready = 1'b0;
    issue(1'b0, 2'd2, 2'd2, 2'd1, 16'h0020, 1'b0, 1'b1);
    for (int n = 0; n < 20 && !rsp_valid; n++) tick();
    check("bp_rsp_valid", {15'd0, rsp_valid}, 16'd1);
    for (int i = 0; i < 10; i++) begin
      cmd_valid = (i == 3);
      cmd_op = 1'b1; cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_dst = 2'd0;
      tick();
      check("bp_cmd_ready", {15'd0, cmd_ready}, 16'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("bp_idle_after_release", {15'd0, cmd_ready}, 16'd1);
    drain();

    // Hazard: src_a == src_b == dst, with a host write to r3 during CAPT.
    preload(2'd3, 16'h0007);
    issue(1'b0, 2'd3, 2'd3, 2'd3, 16'h000E, 1'b0, 1'b1);
    tick();
    tick();
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 16'h0063;
    tick();
    wr_en = 1'b0;
    drain();
    preload(2'd0, 16'h0000);
    issue(1'b0, 2'd3, 2'd0, 2'd1, 16'h000E, 1'b0, 1'b1);
    drain();

    // Error detect: segment result forced one above the true sum.
    preload(2'd0, 16'h0005);
    preload(2'd1, 16'h0006);
    delta = 16'd1;
    issue(1'b0, 2'd0, 2'd1, 2'd2, 16'h000C, 1'b1, 1'b1);
    drain();
    delta = 16'd0;

    // Reset in EXEC: command abandoned, outputs cleared at once, rf cleared.
    issue(1'b1, 2'd0, 2'd1, 2'd2, 16'h0000, 1'b0, 1'b0);
    tick();
    check("pre_reset_seg_r1", seg_r1, 16'h0005);
    rst = 1'b1;
    #1;
    check("midexec_seg_r1", seg_r1, 16'd0);
    check("midexec_seg_r4", seg_r4, 16'd0);
    check("midexec_ctl", {13'd0, seg_s2, seg_op, rsp_valid}, 16'd0);
    tick();
    rst = 1'b0;
    tick();
    check("cmd_ready_after_midexec", {15'd0, cmd_ready}, 16'd1);
    issue(1'b0, 2'd0, 2'd1, 2'd2, 16'h0000, 1'b0, 1'b1);
    drain();
    issue(1'b0, 2'd2, 2'd3, 2'd0, 16'h0000, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 8; i++) tick();
    check("queue_empty_at_end", exp_q.size(), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
